// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch unit
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        adel;
    } fetch_out_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: single-outstanding instruction bus between fetch (master) and memory (slave)
interface fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, addr, input addr_ok, data_ok, rdata);
    modport slave  (input req, addr, output addr_ok, data_ok, rdata);

endinterface

// File: rtl/fetch.sv
// fetch: instruction fetch with delayed branch and immediate flush; optional FETCH_ALIGN_CHECK_EN address check
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    fetch_if.master     ibus,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    output logic        out_adel
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, tgt_q, tgt_d;
    logic         pend_q, pend_d;
    fetch_out_t   out_q, out_d;
    logic         can_load, misalign, accept;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = |pc_q[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign can_load    = ~out_q.valid | ~stall;
    assign ibus.req    = (state_q == S_REQ) & can_load & ~misalign;
    assign ibus.addr   = pc_q;
    assign accept      = ibus.req & ibus.addr_ok;
    assign out_valid   = out_q.valid;
    assign out_instr   = out_q.instr;
    assign out_pc      = out_q.pc;
    assign out_pcplus4 = out_q.pcplus4;
    assign out_adel    = out_q.adel;

    // next state: bus handshake, delivery into the output register, then branch and flush redirects
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        out_d   = out_q;
        if (out_q.valid & ~stall) out_d.valid = 1'b0;
        case (state_q)
            S_REQ:   if (accept) state_d = S_WAIT;
            S_WAIT: begin
                if (ibus.data_ok) begin
                    out_d   = '{valid: 1'b1, instr: ibus.rdata, pc: pc_q, pcplus4: pc_q + 32'd4, adel: 1'b0};
                    pc_d    = pend_q ? tgt_q : pc_q + 32'd4;
                    pend_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: if (ibus.data_ok) state_d = S_REQ;
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        if ((state_q == S_REQ) & misalign & can_load)
            out_d = '{valid: 1'b1, instr: 32'd0, pc: pc_q, pcplus4: pc_q + 32'd4, adel: 1'b1};
`endif
        if (branch_valid) begin
            pend_d = 1'b1;
            tgt_d  = branch_target;
        end
        if (flush_valid) begin
            out_d.valid = 1'b0;
            pc_d        = flush_pc;
            pend_d      = 1'b0;
            state_d     = (((state_q == S_REQ) & ~accept) | ((state_q != S_REQ) & ibus.data_ok)) ? S_REQ : S_DROP;
        end
    end

    // state, pc, pending branch and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized bench for fetch against a transaction-level model of the fetch stream
module tb_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, branch_valid = 1'b0, flush_valid = 1'b0;
    logic [31:0] branch_target = '0, flush_pc = '0;
    logic        out_valid, out_adel;
    logic [31:0] out_instr, out_pc, out_pcplus4;

    fetch_if ibus ();

    fetch dut (
        .clk          (clk),
        .reset        (reset),
        .ibus         (ibus.master),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .flush_valid  (flush_valid),
        .flush_pc     (flush_pc),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pcplus4  (out_pcplus4),
        .out_adel     (out_adel)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // model of the architectural fetch stream and the one bus transaction in flight
    logic        m_valid = 0, m_pend = 0, outst = 0, m_disc = 0;
    logic [31:0] m_instr = 0, m_opc = 0, m_pc = 32'hBFC0_0000, m_tgt = 0, t_addr = 0, t_data = 0;
    int          lat = 0, lat_sel = 0;
    logic        dd_en = 0, aok = 0, mdl_on = 1, last_req = 0;
    logic [31:0] dd = 0, last_addr = 0;
    logic [31:0] seen[$];

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    function automatic int idx_of(logic [31:0] v);
        foreach (seen[i]) if (seen[i] == v) return i;
        return -1;
    endfunction

    // one clock: drive at negedge, compare, advance the model, wait for next negedge
    task automatic tick();
        logic exp_req, acc, d;
        ibus.addr_ok = aok;
        ibus.data_ok = outst && lat == 0;
        ibus.rdata   = ibus.data_ok ? t_data : $urandom;
        #1;
        last_req  = ibus.req;
        last_addr = ibus.addr;
        if (out_valid && !stall && !flush_valid) seen.push_back(out_pc);
        exp_req = !outst && (!m_valid || !stall);
        if (mdl_on) begin
            chk("req", ibus.req, exp_req);
            if (exp_req) chk("addr", ibus.addr, m_pc);
            chk("valid", out_valid, m_valid);
            if (m_valid) begin
                chk("instr", out_instr, m_instr);
                chk("pc", out_pc, m_opc);
                chk("pcplus4", out_pcplus4, m_opc + 32'd4);
                chk("adel", out_adel, 0);
            end
        end
        acc = exp_req && aok;
        d   = ibus.data_ok;
        if (m_valid && !stall) m_valid = 0;
        if (outst && !d) lat--;
        if (d) begin
            if (!m_disc && !flush_valid) begin
                m_valid = 1;
                m_instr = t_data;
                m_opc   = t_addr;
                m_pc    = m_pend ? m_tgt : t_addr + 32'd4;
                m_pend  = 0;
            end
            outst = 0;
        end
        if (acc) begin
            outst  = 1;
            t_addr = m_pc;
            t_data = dd_en ? dd : $urandom;
            m_disc = 0;
            lat    = lat_sel >= 0 ? lat_sel : int'($urandom_range(0, 3));
        end
        if (branch_valid && !flush_valid) begin
            m_pend = 1;
            m_tgt  = branch_target;
        end
        if (flush_valid) begin
            m_valid = 0;
            m_pc    = flush_pc;
            m_pend  = 0;
            if (outst) m_disc = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int i, n0, k;
        ibus.addr_ok = 0;
        ibus.data_ok = 0;
        ibus.rdata   = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pcplus4", out_pcplus4, 0);
        chk("rst_adel", out_adel, 0);
        chk("rst_req", ibus.req, 1);
        chk("rst_addr", ibus.addr, 32'hBFC0_0000);

        aok = 1; dd_en = 1; dd = 32'h2408_0001;
        tick();
        chk("first_req", last_req, 1);
        chk("first_addr", last_addr, 32'hBFC0_0000);
        aok = 0; dd_en = 0;
        tick();
        chk("d1_valid", out_valid, 1);
        chk("d1_instr", out_instr, 32'h2408_0001);
        chk("d1_pc", out_pc, 32'hBFC0_0000);
        chk("d1_pcplus4", out_pcplus4, 32'hBFC0_0004);
        chk("d1_next_addr", ibus.addr, 32'hBFC0_0004);

        stall = 1;
        repeat (5) begin
            tick();
            chk("stall_req", last_req, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_pc", out_pc, 32'hBFC0_0000);
            chk("stall_instr", out_instr, 32'h2408_0001);
        end
        stall = 0; aok = 1;
        tick();
        chk("unstall_req", last_req, 1);

        seen.delete();
        for (k = 0; k < 20 && !(m_valid && m_opc == 32'hBFC0_0008); k++) tick();
        chk("reach_bfc00008", k < 20, 1);
        branch_valid = 1; branch_target = 32'h8000_0100;
        tick();
        branch_valid = 0;
        repeat (10) tick();
        i = idx_of(32'hBFC0_0008);
        chk("delay_slot", (i >= 0 && seen.size() > i + 2) ? seen[i+1] : 32'hx, 32'hBFC0_000C);
        chk("branch_tgt", (i >= 0 && seen.size() > i + 2) ? seen[i+2] : 32'hx, 32'h8000_0100);

        n0 = seen.size();
        repeat (10) tick();
        chk("throughput", seen.size() - n0, 5);

        lat_sel = 3;
        for (k = 0; k < 10 && !(outst && lat == 3); k++) tick();
        chk("reach_wait", k < 10, 1);
        aok = 0; flush_valid = 1; flush_pc = 32'h8000_0180;
        tick();
        flush_valid = 0;
        repeat (3) begin
            tick();
            chk("drop_req", last_req, 0);
            chk("drop_valid", out_valid, 0);
        end
        tick();
        chk("after_drop_req", last_req, 1);
        chk("after_drop_addr", last_addr, 32'h8000_0180);
        chk("after_drop_valid", out_valid, 0);

        aok = 1; lat_sel = 0;
        seen.delete();
        for (k = 0; k < 20 && !m_valid; k++) tick();
        flush_valid = 1; flush_pc = 32'h8000_0200;
        branch_valid = 1; branch_target = 32'h8000_0300;
        tick();
        flush_valid = 0; branch_valid = 0;
        repeat (12) tick();
        chk("flush_wins_seen", idx_of(32'h8000_0200) >= 0, 1);
        chk("branch_ignored", idx_of(32'h8000_0300) >= 0, 0);

        seen.delete();
        flush_valid = 1; flush_pc = 32'hFFFF_FFFC;
        tick();
        flush_valid = 0;
        repeat (12) tick();
        i = idx_of(32'hFFFF_FFFC);
        chk("wrap", (i >= 0 && seen.size() > i + 1) ? seen[i+1] : 32'hx, 32'h0000_0000);

        lat_sel = -1;
        repeat (3000) begin
            stall         = $urandom_range(0, 9) < 3;
            aok           = $urandom_range(0, 9) < 6;
            flush_valid   = $urandom_range(0, 49) == 0;
            flush_pc      = $urandom & 32'hFFFF_FFFC;
            branch_valid  = m_valid && !stall && !m_pend && $urandom_range(0, 3) == 0;
            branch_target = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        stall = 0; flush_valid = 0; branch_valid = 0;

`ifdef FETCH_ALIGN_CHECK_EN
        mdl_on = 0; aok = 1;
        flush_valid = 1; flush_pc = 32'h8000_0002;
        tick();
        flush_valid = 0;
        repeat (6) tick();
        tick();
        chk("align_req", last_req, 0);
        chk("align_valid", out_valid, 1);
        chk("align_adel", out_adel, 1);
        chk("align_pc", out_pc, 32'h8000_0002);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
